// File: rtl/light_sequencer.sv
// light_sequencer
//   Drives the main-road and sub-road signal heads, the pedestrian walk
//   lamps and a remaining-seconds count from the controller's mode flags.
//   A prescaler divides clk down to a one-second tick. All phase timing is
//   counted in ticks.
//
// Parameters
//   TICK_DIV      clk cycles per one-second tick
//   MAIN_GREEN_S  base main-green seconds
//   SUB_GREEN_S   base sub-green seconds
//   YELLOW_S      yellow seconds, both roads
//   MORE_EXTRA_S  extra green seconds under busy-hour bias
//
// Ports
//   clk, Reset                 clock, synchronous active-high reset
//   Source, off_r              power present / forced off
//   pause_r                    freeze everything (prescaler included)
//   polic, star_change         police mode / night flash mode
//   online_r, *_change         forced constant lights
//   busy_r, main_more/sub_more busy-hour green extension
//   main_man, sub_man          pedestrian requests
//   main_light, sub_light      {R,Y,G} heads
//   main_walk, sub_walk        walk lamps
//   count                      seconds left in the current cycle phase
//   tick                       one-cycle pulse per second
module light_sequencer #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int MAIN_GREEN_S = 30,
  parameter int SUB_GREEN_S  = 20,
  parameter int YELLOW_S     = 3,
  parameter int MORE_EXTRA_S = 10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Source,
  input  logic       off_r,
  input  logic       pause_r,
  input  logic       polic,
  input  logic       star_change,
  input  logic       online_r,
  input  logic       main_green_change,
  input  logic       sub_red_change,
  input  logic       main_red_change,
  input  logic       sub_green_change,
  input  logic       busy_r,
  input  logic       main_more,
  input  logic       sub_more,
  input  logic       main_man,
  input  logic       sub_man,
  output logic [2:0] main_light,
  output logic [2:0] sub_light,
  output logic       main_walk,
  output logic       sub_walk,
  output logic [7:0] count,
  output logic       tick
);

  localparam logic [2:0] ST_OFF   = 3'd0;
  localparam logic [2:0] ST_MG    = 3'd1;
  localparam logic [2:0] ST_MY    = 3'd2;
  localparam logic [2:0] ST_SG    = 3'd3;
  localparam logic [2:0] ST_SY    = 3'd4;
  localparam logic [2:0] ST_FORCE = 3'd5;
  localparam logic [2:0] ST_POL   = 3'd6;
  localparam logic [2:0] ST_NIGHT = 3'd7;

  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_R   = 3'b100;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_G   = 3'b001;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [7:0] MG_BASE  = 8'(MAIN_GREEN_S);
  localparam logic [7:0] SG_BASE  = 8'(SUB_GREEN_S);
  localparam logic [7:0] YEL_DUR  = 8'(YELLOW_S);
  localparam logic [7:0] EXTRA    = 8'(MORE_EXTRA_S);

  logic [2:0]    state_reg, state_next;
  logic [7:0]    count_reg, count_next;
  logic [PW-1:0] presc_reg, presc_next, presc_step;
  logic          flash_reg, flash_next;
  logic          tick_reg, tick_next;
  logic          main_req_reg, main_req_next;
  logic          sub_req_reg, sub_req_next;
  logic [2:0]    main_light_reg, main_light_next;
  logic [2:0]    sub_light_reg, sub_light_next;
  logic          main_walk_reg, main_walk_next;
  logic          sub_walk_reg, sub_walk_next;

  logic          wrap, off_cond, hold, force_cond, cycling;
  logic [7:0]    mg_dur, sg_dur;

  always_comb begin
    wrap       = (presc_reg == PRESC_MAX);
    presc_step = wrap ? '0 : presc_reg + 1'b1;
    off_cond   = !Source || off_r;
    hold       = !off_cond && pause_r;
    force_cond = online_r | main_green_change | sub_red_change |
                 main_red_change | sub_green_change;
    cycling    = (state_reg == ST_MG) || (state_reg == ST_MY) ||
                 (state_reg == ST_SG) || (state_reg == ST_SY);
    // Green extensions are sampled at the moment the phase is loaded.
    mg_dur     = MG_BASE + ((busy_r & main_more) ? EXTRA : 8'd0);
    sg_dur     = SG_BASE + ((busy_r & sub_more) ? EXTRA : 8'd0);

    state_next      = state_reg;
    count_next      = count_reg;
    presc_next      = presc_reg;
    flash_next      = flash_reg;
    tick_next       = 1'b0;
    main_req_next   = main_req_reg;
    sub_req_next    = sub_req_reg;
    main_light_next = main_light_reg;
    sub_light_next  = sub_light_reg;
    main_walk_next  = main_walk_reg;
    sub_walk_next   = sub_walk_reg;

    if (off_cond) begin
      state_next = ST_OFF;
      count_next = 8'd0;
      presc_next = '0;
    end else if (pause_r) begin
      // Everything holds; tick stays low so no second is lost or added.
    end else begin
      presc_next = presc_step;
      tick_next  = wrap;
      if (polic) begin
        state_next = ST_POL;
        count_next = 8'd0;
      end else if (star_change) begin
        count_next = 8'd0;
        if (state_reg != ST_NIGHT) begin
          // Restart the flash cadence from a lit half-period.
          state_next = ST_NIGHT;
          flash_next = 1'b1;
          presc_next = '0;
          tick_next  = 1'b0;
        end else if (wrap) begin
          flash_next = ~flash_reg;
        end
      end else if (force_cond) begin
        state_next = ST_FORCE;
        count_next = 8'd0;
      end else if (!cycling) begin
        // Cycle always restarts at MG with a fresh second boundary.
        state_next = ST_MG;
        count_next = mg_dur;
        presc_next = '0;
        tick_next  = 1'b0;
      end else if (wrap) begin
        if (count_reg == 8'd1) begin
          case (state_reg)
            ST_MG:   begin state_next = ST_MY; count_next = YEL_DUR; end
            ST_MY:   begin state_next = ST_SG; count_next = sg_dur;  end
            ST_SG:   begin state_next = ST_SY; count_next = YEL_DUR; end
            default: begin state_next = ST_MG; count_next = mg_dur;  end
          endcase
        end else begin
          count_next = count_reg - 8'd1;
        end
      end
    end

    // A request raised on the very cycle its phase ends re-arms for next time.
    if (off_cond) begin
      main_req_next = 1'b0;
      sub_req_next  = 1'b0;
    end else begin
      main_req_next = (main_req_reg & ~((state_reg == ST_SG) && (state_next != ST_SG)))
                      | main_man;
      sub_req_next  = (sub_req_reg & ~((state_reg == ST_MG) && (state_next != ST_MG)))
                      | sub_man;
    end

    if (!hold) begin
      main_walk_next = (state_next == ST_SG) & main_req_next;
      sub_walk_next  = (state_next == ST_MG) & sub_req_next;
      case (state_next)
        ST_MG:    begin main_light_next = L_G; sub_light_next = L_R; end
        ST_MY:    begin main_light_next = L_Y; sub_light_next = L_R; end
        ST_SG:    begin main_light_next = L_R; sub_light_next = L_G; end
        ST_SY:    begin main_light_next = L_R; sub_light_next = L_Y; end
        ST_POL:   begin main_light_next = L_R; sub_light_next = L_R; end
        ST_NIGHT: begin
          main_light_next = {1'b0, flash_next, 1'b0};
          sub_light_next  = {1'b0, flash_next, 1'b0};
        end
        ST_FORCE: begin
          main_light_next = (online_r | main_green_change) ? L_G : L_R;
          sub_light_next  = sub_green_change ? L_G : L_R;
        end
        default:  begin main_light_next = L_OFF; sub_light_next = L_OFF; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_reg      <= ST_OFF;
      count_reg      <= 8'd0;
      presc_reg      <= '0;
      flash_reg      <= 1'b0;
      tick_reg       <= 1'b0;
      main_req_reg   <= 1'b0;
      sub_req_reg    <= 1'b0;
      main_light_reg <= L_OFF;
      sub_light_reg  <= L_OFF;
      main_walk_reg  <= 1'b0;
      sub_walk_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      presc_reg      <= presc_next;
      flash_reg      <= flash_next;
      tick_reg       <= tick_next;
      main_req_reg   <= main_req_next;
      sub_req_reg    <= sub_req_next;
      main_light_reg <= main_light_next;
      sub_light_reg  <= sub_light_next;
      main_walk_reg  <= main_walk_next;
      sub_walk_reg   <= sub_walk_next;
    end
  end

  assign main_light = main_light_reg;
  assign sub_light  = sub_light_reg;
  assign main_walk  = main_walk_reg;
  assign sub_walk   = sub_walk_reg;
  assign count      = count_reg;
  assign tick       = tick_reg;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer: a directed vector table, a few
// hand-written multi-cycle sequences, then randomized stimulus checked
// against a time-based reference model.
module tb_light_sequencer;

  localparam int TD = 4;
  localparam int MGS = 5;
  localparam int SGS = 3;
  localparam int YS = 2;
  localparam int EX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset, Source, off_r, pause_r, polic, star_change, online_r;
  logic main_green_change, sub_red_change, main_red_change, sub_green_change;
  logic busy_r, main_more, sub_more, main_man, sub_man;
  logic [2:0] main_light, sub_light;
  logic main_walk, sub_walk, tick;
  logic [7:0] count;

  light_sequencer #(
    .TICK_DIV(TD), .MAIN_GREEN_S(MGS), .SUB_GREEN_S(SGS),
    .YELLOW_S(YS), .MORE_EXTRA_S(EX)
  ) dut (
    .clk(clk), .Reset(Reset), .Source(Source), .off_r(off_r), .pause_r(pause_r),
    .polic(polic), .star_change(star_change), .online_r(online_r),
    .main_green_change(main_green_change), .sub_red_change(sub_red_change),
    .main_red_change(main_red_change), .sub_green_change(sub_green_change),
    .busy_r(busy_r), .main_more(main_more), .sub_more(sub_more),
    .main_man(main_man), .sub_man(sub_man),
    .main_light(main_light), .sub_light(sub_light),
    .main_walk(main_walk), .sub_walk(sub_walk), .count(count), .tick(tick)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    Reset = 0; Source = 0; off_r = 0; pause_r = 0; polic = 0; star_change = 0;
    online_r = 0; main_green_change = 0; sub_red_change = 0; main_red_change = 0;
    sub_green_change = 0; busy_r = 0; main_more = 0; sub_more = 0;
    main_man = 0; sub_man = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1;
    cyc(1);
    Reset = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, src, busy, mmore, star, online, pol;
    int n;
    int e_main, e_sub, e_cnt;
  } vec_t;

  vec_t vt[22];

  // ---------------- reference model ----------------
  // Modes: 0 off, 1 cycling, 2 police, 3 night, 4 forced.
  // Time is kept as cycles since the last prescaler restart (m_ps); phase
  // progress and flash are derived from it arithmetically.
  int m_mode, m_ph, m_dur, m_start, m_ps;
  bit m_mreq, m_sreq;
  int e_main, e_sub, e_mw, e_sw, e_cnt, e_tick;
  int ph_main[4] = '{1, 2, 4, 4};
  int ph_sub[4]  = '{4, 4, 1, 2};

  function automatic int dur_of(input int ph);
    case (ph)
      0: return MGS + ((busy_r && main_more) ? EX : 0);
      2: return SGS + ((busy_r && sub_more) ? EX : 0);
      default: return YS;
    endcase
  endfunction

  task automatic model_step();
    bit was_mg, was_sg, in_mg, in_sg;
    bit flash;
    was_mg = (m_mode == 1 && m_ph == 0);
    was_sg = (m_mode == 1 && m_ph == 2);
    if (Reset || !Source || off_r) begin
      m_mode = 0; m_ps = 0; m_mreq = 0; m_sreq = 0;
      e_main = 0; e_sub = 0; e_mw = 0; e_sw = 0; e_cnt = 0; e_tick = 0;
      return;
    end
    if (pause_r) begin
      e_tick = 0;
      m_mreq = m_mreq | main_man;
      m_sreq = m_sreq | sub_man;
      return;
    end
    m_ps++;
    e_tick = (m_ps % TD == 0);
    if (polic) m_mode = 2;
    else if (star_change) begin
      if (m_mode != 3) begin m_mode = 3; m_ps = 0; e_tick = 0; end
    end else if (online_r || main_green_change || sub_red_change ||
                 main_red_change || sub_green_change) m_mode = 4;
    else if (m_mode != 1) begin
      m_mode = 1; m_ph = 0; m_ps = 0; m_start = 0; m_dur = dur_of(0); e_tick = 0;
    end else if (m_ps - m_start == m_dur * TD) begin
      m_ph = (m_ph + 1) % 4; m_start = m_ps; m_dur = dur_of(m_ph);
    end
    in_mg = (m_mode == 1 && m_ph == 0);
    in_sg = (m_mode == 1 && m_ph == 2);
    if (was_sg && !in_sg) m_mreq = 0;
    if (was_mg && !in_mg) m_sreq = 0;
    m_mreq = m_mreq | main_man;
    m_sreq = m_sreq | sub_man;
    e_mw = (in_sg && m_mreq) ? 1 : 0;
    e_sw = (in_mg && m_sreq) ? 1 : 0;
    e_cnt = 0;
    case (m_mode)
      1: begin
        e_main = ph_main[m_ph]; e_sub = ph_sub[m_ph];
        e_cnt = m_dur - (m_ps - m_start) / TD;
      end
      2: begin e_main = 4; e_sub = 4; end
      3: begin
        flash = ((m_ps / TD) % 2 == 0);
        e_main = flash ? 2 : 0; e_sub = flash ? 2 : 0;
      end
      default: begin
        e_main = (online_r || main_green_change) ? 1 : 4;
        e_sub = sub_green_change ? 1 : 4;
      end
    endcase
  endtask

  initial begin
    clear_inputs();
    //           rst src busy mm star onl pol  n  main sub cnt
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 0, 0, 0, 0,  1, 1, 4, 5};
    vt[2]  = '{0, 1, 0, 0, 0, 0, 0, 19, 1, 4, 1};
    vt[3]  = '{0, 1, 0, 0, 0, 0, 0,  1, 2, 4, 2};
    vt[4]  = '{0, 1, 0, 0, 0, 0, 0,  8, 4, 1, 3};
    vt[5]  = '{0, 1, 0, 0, 0, 0, 0, 12, 4, 2, 2};
    vt[6]  = '{0, 1, 0, 0, 0, 0, 0,  8, 1, 4, 5};
    vt[7]  = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[8]  = '{0, 1, 1, 1, 0, 0, 0,  1, 1, 4, 9};
    vt[9]  = '{0, 1, 1, 1, 0, 0, 0, 35, 1, 4, 1};
    vt[10] = '{0, 1, 1, 1, 0, 0, 0,  1, 2, 4, 2};
    vt[11] = '{1, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0};
    vt[12] = '{0, 1, 0, 1, 0, 0, 0,  1, 1, 4, 5};
    vt[13] = '{0, 1, 0, 1, 0, 0, 0, 19, 1, 4, 1};
    vt[14] = '{0, 1, 0, 1, 0, 0, 0,  1, 2, 4, 2};
    vt[15] = '{0, 1, 0, 0, 1, 0, 0,  1, 2, 2, 0};
    vt[16] = '{0, 1, 0, 0, 1, 0, 0,  3, 2, 2, 0};
    vt[17] = '{0, 1, 0, 0, 1, 0, 0,  1, 0, 0, 0};
    vt[18] = '{0, 1, 0, 0, 1, 0, 0,  4, 2, 2, 0};
    vt[19] = '{0, 1, 0, 0, 0, 0, 0,  1, 1, 4, 5};
    vt[20] = '{0, 1, 0, 0, 0, 0, 1,  1, 4, 4, 0};
    vt[21] = '{0, 1, 0, 0, 0, 1, 0,  1, 1, 4, 0};

    cyc(2);
    for (int i = 0; i < 22; i++) begin
      Reset = vt[i].rst; Source = vt[i].src; busy_r = vt[i].busy;
      main_more = vt[i].mmore; star_change = vt[i].star;
      online_r = vt[i].online; polic = vt[i].pol;
      cyc(vt[i].n);
      chk($sformatf("vec%0d main_light", i), int'(main_light), vt[i].e_main);
      chk($sformatf("vec%0d sub_light", i), int'(sub_light), vt[i].e_sub);
      chk($sformatf("vec%0d count", i), int'(count), vt[i].e_cnt);
      $display("vec %0d: main=%b sub=%b count=%0d", i, main_light, sub_light, count);
    end

    // Pause for 10 cycles at count=3 delays MY by exactly 10 cycles.
    do_reset();
    Source = 1;
    cyc(1);
    cyc(8);
    chk("pause pre count", int'(count), 3);
    pause_r = 1;
    cyc(10);
    chk("pause count held", int'(count), 3);
    chk("pause main held", int'(main_light), 1);
    chk("pause tick low", int'(tick), 0);
    pause_r = 0;
    cyc(11);
    chk("pause resume count", int'(count), 1);
    chk("pause resume main", int'(main_light), 1);
    cyc(1);
    chk("pause MY entry", int'(main_light), 2);
    chk("pause MY count", int'(count), 2);
    $display("pause sequence: main=%b count=%0d", main_light, count);

    // Sub-road request in SG serves the next MG only.
    do_reset();
    Source = 1;
    cyc(1);
    cyc(28);
    chk("walk SG entry", int'(sub_light), 1);
    sub_man = 1;
    cyc(1);
    sub_man = 0;
    cyc(11);
    chk("walk SY sub_walk", int'(sub_walk), 0);
    cyc(8);
    chk("walk MG sub_walk", int'(sub_walk), 1);
    chk("walk MG main", int'(main_light), 1);
    cyc(19);
    chk("walk MG end sub_walk", int'(sub_walk), 1);
    cyc(1);
    chk("walk MY sub_walk", int'(sub_walk), 0);
    chk("walk MY main", int'(main_light), 2);
    $display("walk sequence: sub_walk=%b main=%b", sub_walk, main_light);

    // Police with a main request: red/red, no walk; request served in SG.
    polic = 1; main_man = 1;
    cyc(1);
    main_man = 0;
    chk("pol main", int'(main_light), 4);
    chk("pol sub", int'(sub_light), 4);
    chk("pol main_walk", int'(main_walk), 0);
    cyc(5);
    chk("pol held main_walk", int'(main_walk), 0);
    chk("pol held count", int'(count), 0);
    polic = 0;
    cyc(1);
    chk("pol exit count", int'(count), 5);
    cyc(28);
    chk("pol SG main_walk", int'(main_walk), 1);
    cyc(12);
    chk("SY main_walk", int'(main_walk), 0);
    chk("SY sub", int'(sub_light), 2);
    online_r = 1;
    cyc(1);
    chk("online main", int'(main_light), 1);
    chk("online sub", int'(sub_light), 4);
    chk("online count", int'(count), 0);
    online_r = 0;
    cyc(4);
    Reset = 1; polic = 1;
    cyc(1);
    chk("rst main", int'(main_light), 0);
    chk("rst sub", int'(sub_light), 0);
    chk("rst count", int'(count), 0);
    chk("rst tick", int'(tick), 0);
    chk("rst walks", int'({main_walk, sub_walk}), 0);
    $display("mode sequence: main=%b sub=%b count=%0d", main_light, sub_light, count);

    // Randomized segments against the reference model.
    clear_inputs();
    for (int seg = 0; seg < 80; seg++) begin
      int r, len;
      r = (seg == 0) ? 0 : int'($urandom_range(0, 99));
      len = int'($urandom_range(1, 40));
      clear_inputs();
      Source = 1;
      busy_r = $urandom_range(0, 1) == 1;
      main_more = $urandom_range(0, 1) == 1;
      sub_more = $urandom_range(0, 1) == 1;
      if (r < 4) begin Reset = 1; len = 1; end
      else if (r < 8) Source = 0;
      else if (r < 11) off_r = 1;
      else if (r < 23) pause_r = 1;
      else if (r < 30) polic = 1;
      else if (r < 38) star_change = 1;
      else if (r < 48) begin
        online_r = $urandom_range(0, 3) == 0;
        main_green_change = $urandom_range(0, 2) == 0;
        main_red_change = $urandom_range(0, 2) == 0;
        sub_green_change = $urandom_range(0, 2) == 0;
        sub_red_change = !(online_r | main_green_change | main_red_change | sub_green_change);
      end else len = len + 40;
      for (int k = 0; k < len; k++) begin
        main_man = $urandom_range(0, 15) == 0;
        sub_man = $urandom_range(0, 15) == 0;
        model_step();
        cyc(1);
        chk("rnd main_light", int'(main_light), e_main);
        chk("rnd sub_light", int'(sub_light), e_sub);
        chk("rnd main_walk", int'(main_walk), e_mw);
        chk("rnd sub_walk", int'(sub_walk), e_sw);
        chk("rnd count", int'(count), e_cnt);
        chk("rnd tick", int'(tick), e_tick);
      end
      $display("seg %0d: kind=%0d len=%0d main=%b sub=%b count=%0d", seg, r, len,
               main_light, sub_light, count);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Phase sequencer directly downstream of the traffic main controller. It consumes the controller's registered mode flags (power, pause, police, night, online, forced green/red, busy-hour bias, pedestrian requests) and drives the actual main-road and sub-road signal heads. It also drives the pedestrian walk lamps and a remaining-seconds count for the display stage. A prescaler derives a 1-second tick from `clk`; all phase timing is counted in ticks.

## Interface

- `TICK_DIV`, 100_000_000: `clk` cycles per one-second tick.
- `MAIN_GREEN_S`, 30: base main-green seconds.
- `SUB_GREEN_S`, 20: base sub-green seconds.
- `YELLOW_S`, 3: yellow seconds, both roads.
- `MORE_EXTRA_S`, 10: extra green seconds under busy-hour bias.
- `clk` in 1: single clock.
- `Reset` in 1: synchronous, active-high.
- `Source` in 1: 0 = power off.
- `off_r` in 1: forced off.
- `pause_r` in 1: freeze.
- `polic` in 1: police mode.
- `star_change` in 1: night flash mode.
- `online_r` in 1: online mode (main green, sub red).
- `main_green_change`, `sub_red_change`, `main_red_change`, `sub_green_change` in 1 each: forced constant lights.
- `busy_r`, `main_more`, `sub_more` in 1 each: busy-hour green extension.
- `main_man`, `sub_man` in 1 each: pedestrian requests.
- `main_light` out 3: {R,Y,G}, main road.
- `sub_light` out 3: {R,Y,G}, sub road.
- `main_walk`, `sub_walk` out 1 each: walk lamps.
- `count` out 8: seconds remaining in current cycle phase, unsigned.
- `tick` out 1: one-cycle pulse each second.

## Operation

- States: OFF, MG (main G / sub R), MY (main Y / sub R), SG (main R / sub G), SY (main R / sub Y), FORCE, POL, NIGHT.
- Evaluated every cycle, highest priority first: `Reset` -> OFF. `!Source | off_r` -> OFF. `pause_r` -> hold all state, prescaler, count and outputs. `polic` -> POL. `star_change` -> NIGHT. `online_r` or any `*_change` -> FORCE. Otherwise run the cycle.
- Entering the cycle from OFF, FORCE, POL or NIGHT: go to MG, load `count` with the MG duration, clear the prescaler.
- Cycle order is MG -> MY -> SG -> SY -> MG.
- MG duration = `MAIN_GREEN_S` + (`busy_r & main_more` ? `MORE_EXTRA_S` : 0), sampled at load.
- SG duration = `SUB_GREEN_S` + (`busy_r & sub_more` ? `MORE_EXTRA_S` : 0), sampled at load.
- MY and SY durations = `YELLOW_S`.
- On `tick`: if `count == 1`, advance phase and load the next duration; else decrement `count`. `count` never reaches 0 while cycling.
- OFF: all lights 000, walks 0, `count` 0.
- POL: both roads R (100), `count` 0, walks 0.
- NIGHT: both roads {0,flash,0}. `flash` is set to 1 and the prescaler cleared on entry; `flash` toggles on each `tick`. `count` 0.
- FORCE: `online_r` or `main_green_change` gives main G, else `main_red_change` gives main R, else main R. Sub road: `sub_green_change` gives G, else R. `count` 0.
- Pedestrian latches: `main_man` high in any cycle sets `main_req`; `sub_man` sets `sub_req`. Both latches clear in OFF.
- `main_walk` = SG & `main_req`; `main_req` clears on exit from SG.
- `sub_walk` = MG & `sub_req`; `sub_req` clears on exit from MG.
- Arithmetic: durations are computed at 8 bits. Parameter sums above 255 are a configuration error.

## Timing

- All outputs are registered. A change on any input is visible on the outputs one `clk` edge later.
- Reset values: state OFF, `main_light` = `sub_light` = 000, walks 0, `count` 0, `tick` 0, prescaler 0, `flash` 0, `main_req` = `sub_req` = 0.
- Prescaler counts 0..`TICK_DIV`-1. `tick` pulses one cycle on wrap and is gated while paused.
- A phase of N seconds lasts exactly N×`TICK_DIV` cycles from load to the next phase.
- Pause releases mid-phase resume with the same `count` and prescaler value. No tick is lost or added.
- Mode exit to the cycle always restarts at MG. There is no phase memory.
- `Reset` asserted mid-phase: OFF on the next edge, regardless of other inputs.

## Test plan

Use `TICK_DIV`=4, `MAIN_GREEN_S`=5, `SUB_GREEN_S`=3, `YELLOW_S`=2, `MORE_EXTRA_S`=4 unless stated.

- Reset, then `Source`=1 with all flags 0 -> MG with `count`=5. Counts 5,4,3,2,1 across ticks; MY at cycle 20 after entry. Then SG (`count`=3) at +28, SY at +40, MG at +48; `main_light`/`sub_light` = 001/100, 010/100, 100/001, 100/010.
- `busy_r`=`main_more`=1 before an MG load -> `count` loads 9 and MG lasts 36 cycles. Same test with `busy_r`=0 -> 5.
- `pause_r` pulsed for 10 cycles during MG at `count`=3 -> outputs and `count` frozen. MY is entered exactly 10 cycles later than unpaused.
- `star_change`=1 -> both lights 010 and 000 alternating every 4 cycles, `count`=0. Drop `star_change` -> MG with `count`=5.
- `sub_man` pulsed during SG -> `sub_walk`=1 throughout the next MG, then 0 in MY and later. `main_man` with `polic`=1 -> both lights 100 and walks 0 while `polic` is high.
- `online_r`=1 mid-SY -> 001/100 next edge with `count`=0. `Reset` mid-MG with `polic`=1 -> all outputs at reset values next edge.
